inst_ram_boot_loader: RTL and testbench
=======================================

// Module: inst_ram_boot_loader
// PURPOSE
//   Parametrised boot sequencer between a program ROM and the CPU instruction RAM.
//   Holds the CPU in reset and streams prog_len words from the ROM into inst RAM
//   at consecutive word addresses. Optionally reads back and checks every word,
//   waits SETTLE_CYCLES, then releases the CPU. Replaces hand-sequenced RAM loading
//   with a restartable, length-programmable, self-checking loader.
// PARAMETERS
//   DATA_W        32            instruction word width
//   ADDR_W        32            inst RAM byte-address width
//   PC_INITIAL    32'hbfc00000  byte address of program word 0
//   DEPTH         64            max words loaded; prog_len clamps to DEPTH
//   SETTLE_CYCLES 64            cycles between end of load/verify and CPU release (>=1)
//   VERIFY        1             1 = read back and compare after load; 0 = skip
//   AUTO_START    1             1 = begin LOAD on the first clk after reset deasserts
// PORTS
//   clk                     in   1                 system clock
//   reset                   in   1                 asynchronous reset, active-low
//   start                   in   1                 1-cycle pulse: begin/restart load
//   prog_len                in   clog2(DEPTH+1)    words to load; sampled on start
//   prog_addr               out  clog2(DEPTH)      ROM word index
//   prog_data               in   DATA_W            ROM data, valid 1 cycle after prog_addr
//   inst_ram_write_enable   out  1                 inst RAM write strobe
//   inst_ram_write_address  out  ADDR_W            inst RAM byte address
//   inst_ram_write_data     out  DATA_W            inst RAM write data
//   inst_ram_read_address   out  ADDR_W            readback byte address
//   inst_ram_read_data      in   DATA_W            readback data, valid 1 cycle after address
//   cpu_reset               out  1                 1 = CPU held, 0 = CPU running
//   debug                   out  1                 1 while IDLE/LOAD/VERIFY/SETTLE/ERROR
//   done                    out  1                 1 in RUN
//   error                   out  1                 1 in ERROR
//   err_addr                out  ADDR_W            byte address of first mismatch
// BEHAVIOUR
//   Reset (async, reset=0): state=IDLE, cpu_reset=1, debug=1, all other outputs 0.
//     Asserting reset mid-operation drops write_enable immediately; no partial state kept.
//   IDLE: start, or AUTO_START on the first clk after reset release, latches
//     len = min(prog_len, DEPTH); prog_len is sampled at start, or at reset release
//     for AUTO_START. len==0 -> SETTLE, else LOAD.
//   LOAD: prog_addr = 0..len-1, one per cycle. Word k is written 1 cycle after
//     prog_addr=k, with write_address = PC_INITIAL + 4*k (mod 2^ADDR_W).
//     Exactly len consecutive write_enable cycles, with no gaps.
//   After the last write: -> VERIFY if VERIFY=1, else -> SETTLE.
//   VERIFY: re-fetches ROM word k and drives read_address = PC_INITIAL + 4*k in the
//     same cycle, then compares both on the next cycle. write_enable stays 0.
//     First mismatch -> ERROR with err_addr = that address. All match -> SETTLE.
//   SETTLE: counter 0..SETTLE_CYCLES-1, with cpu_reset=1. On expiry -> RUN.
//   RUN: cpu_reset=0, debug=0, done=1. All other outputs are held at 0.
//   ERROR: cpu_reset=1, error=1; err_addr holds until the next start.
//   start while in RUN or ERROR: restart. cpu_reset=1 and done/error=0 from the next
//     cycle; relatch len and -> LOAD.
//   start while in LOAD, VERIFY or SETTLE is ignored.
//   cpu_reset, debug, done and error are registered outputs (glitch-free).
// TESTING
//   1 VERIFY=0, prog_len=35 -> 35 back-to-back writes to 0xbfc00000..0xbfc00088 with
//     data = ROM; cpu_reset falls exactly SETTLE_CYCLES clocks after the last write; done=1.
//   2 VERIFY=1, RAM model corrupts word 5 -> error=1, err_addr=0xbfc00014, cpu_reset
//     stays 1, done=0; a later start with a clean RAM reaches RUN.
//   3 prog_len=0 -> no write_enable at all; RUN after SETTLE_CYCLES.
//   4 prog_len=DEPTH+10 -> exactly DEPTH writes; last address PC_INITIAL+4*(DEPTH-1).
//   5 start pulse in RUN -> cpu_reset=1 next cycle, debug=1, full reload, RUN again;
//     a start pulse mid-LOAD changes nothing.
//   6 reset low at write k=10 -> write_enable 0 with no clk edge; on release with
//     AUTO_START=1, the reload begins at word 0 / 0xbfc00000.

Source files
------------

// File: rtl/inst_ram_boot_loader.sv
// Boot sequencer: copies prog_len ROM words into inst RAM, optionally reads them back and checks them, then releases the CPU.
// Latency: word k is written 1 cycle after prog_addr=k; the CPU is released SETTLE_CYCLES clocks after the last write or compare.
// Backpressure: none; ROM and RAM are fixed-latency, and start is ignored while a load, verify or settle is in flight.
module inst_ram_boot_loader #(
    parameter int                DATA_W        = 32,
    parameter int                ADDR_W        = 32,
    parameter logic [ADDR_W-1:0] PC_INITIAL    = ADDR_W'(32'hbfc00000),
    parameter int                DEPTH         = 64,
    parameter int                SETTLE_CYCLES = 64,
    parameter int                VERIFY        = 1,
    parameter int                AUTO_START    = 1,
    localparam int               LEN_W         = $clog2(DEPTH + 1),
    localparam int               PA_W          = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [LEN_W-1:0]  prog_len,
    output logic [PA_W-1:0]   prog_addr,
    input  logic [DATA_W-1:0] prog_data,
    output logic              inst_ram_write_enable,
    output logic [ADDR_W-1:0] inst_ram_write_address,
    output logic [DATA_W-1:0] inst_ram_write_data,
    output logic [ADDR_W-1:0] inst_ram_read_address,
    input  logic [DATA_W-1:0] inst_ram_read_data,
    output logic              cpu_reset,
    output logic              debug,
    output logic              done,
    output logic              error,
    output logic [ADDR_W-1:0] err_addr
);

    localparam int SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_VERIFY,
        S_SETTLE,
        S_RUN,
        S_ERROR
    } state_t;

    state_t             state;
    logic [LEN_W-1:0]   len;          // words to process in this pass
    logic [LEN_W-1:0]   idx;          // word currently presented on prog_addr
    logic               fetch_vld;    // prog_addr carries a live fetch this cycle
    logic               wr_en;
    logic [ADDR_W-1:0]  wr_addr;
    logic               cmp_vld;      // ROM and RAM readback data are both valid this cycle
    logic [ADDR_W-1:0]  cmp_addr;     // byte address of the word being compared
    logic [SET_W-1:0]   settle_cnt;

    logic [LEN_W-1:0]   len_in;
    logic               launch;
    logic               last_fetch;
    logic [ADDR_W-1:0]  cur_addr;

    // Clamp the requested length, decide when a new pass begins and form the byte address of the current word
    assign len_in     = (prog_len > LEN_W'(DEPTH)) ? LEN_W'(DEPTH) : prog_len;
    assign launch     = ((state == S_IDLE) && (start || (AUTO_START != 0))) ||
                        (((state == S_RUN) || (state == S_ERROR)) && start);
    assign last_fetch = (idx == (len - LEN_W'(1)));
    assign cur_addr   = PC_INITIAL + (ADDR_W'(idx) << 2);

    // Bus outputs are kept at zero whenever they are not actively carrying a transfer
    assign prog_addr              = fetch_vld ? idx[PA_W-1:0] : '0;
    assign inst_ram_write_enable  = wr_en;
    assign inst_ram_write_address = wr_addr;
    assign inst_ram_write_data    = wr_en ? prog_data : '0;
    assign inst_ram_read_address  = ((state == S_VERIFY) && fetch_vld) ? cur_addr : '0;

    // Boot FSM: state, fetch/write/compare pipeline, settle counter and the registered status outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            len        <= '0;
            idx        <= '0;
            fetch_vld  <= 1'b0;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            cmp_vld    <= 1'b0;
            cmp_addr   <= '0;
            settle_cnt <= '0;
            cpu_reset  <= 1'b1;
            debug      <= 1'b1;
            done       <= 1'b0;
            error      <= 1'b0;
            err_addr   <= '0;
        end else begin
            wr_en    <= 1'b0;
            wr_addr  <= '0;
            cmp_vld  <= 1'b0;
            cmp_addr <= '0;
            if (launch) begin
                // A zero-length program skips straight to the settle delay
                len        <= len_in;
                idx        <= '0;
                settle_cnt <= '0;
                fetch_vld  <= (len_in != '0);
                state      <= (len_in == '0) ? S_SETTLE : S_LOAD;
                cpu_reset  <= 1'b1;
                debug      <= 1'b1;
                done       <= 1'b0;
                error      <= 1'b0;
                err_addr   <= '0;
            end else begin
                case (state)
                    S_LOAD: begin
                        if (fetch_vld) begin
                            wr_en   <= 1'b1;
                            wr_addr <= cur_addr;
                            if (last_fetch) begin
                                fetch_vld <= 1'b0;
                            end else begin
                                idx <= idx + LEN_W'(1);
                            end
                        end else begin
                            // Final write is on the bus this cycle; move on once it lands
                            idx <= '0;
                            if (VERIFY != 0) begin
                                state     <= S_VERIFY;
                                fetch_vld <= 1'b1;
                            end else begin
                                state      <= S_SETTLE;
                                settle_cnt <= '0;
                            end
                        end
                    end
                    S_VERIFY: begin
                        if (cmp_vld && (prog_data != inst_ram_read_data)) begin
                            state     <= S_ERROR;
                            error     <= 1'b1;
                            err_addr  <= cmp_addr;
                            fetch_vld <= 1'b0;
                            idx       <= '0;
                        end else if (fetch_vld) begin
                            cmp_vld  <= 1'b1;
                            cmp_addr <= cur_addr;
                            if (last_fetch) begin
                                fetch_vld <= 1'b0;
                            end else begin
                                idx <= idx + LEN_W'(1);
                            end
                        end else if (cmp_vld) begin
                            // Last word compared clean
                            state      <= S_SETTLE;
                            settle_cnt <= '0;
                            idx        <= '0;
                        end
                    end
                    S_SETTLE: begin
                        if (settle_cnt == SET_W'(SETTLE_CYCLES - 1)) begin
                            state     <= S_RUN;
                            cpu_reset <= 1'b0;
                            debug     <= 1'b0;
                            done      <= 1'b1;
                        end else begin
                            settle_cnt <= settle_cnt + SET_W'(1);
                        end
                    end
                    S_IDLE, S_RUN, S_ERROR: begin
                        // Waiting for start; handled by launch
                    end
                    default: begin
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_inst_ram_boot_loader.sv
// Directed bench for inst_ram_boot_loader: one instance without readback, one with readback and a corruptible RAM model.
// Latency: expectations are hand-computed cycle offsets measured at negedge against a posedge cycle counter.
// Backpressure: not applicable; ROM and RAM models answer one cycle after the address.
module tb_inst_ram_boot_loader;

    localparam logic [31:0] PC     = 32'hbfc00000;
    localparam int          SETTLE = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    // Instance A: no readback
    logic        rst_a_n, a_start;
    logic [6:0]  a_prog_len;
    logic [5:0]  a_prog_addr;
    logic [31:0] a_prog_data, a_wa, a_wd, a_ra, a_err_addr;
    logic        a_we, a_cpu_reset, a_debug, a_done, a_error;

    // Instance B: readback enabled
    logic        rst_b_n, b_start;
    logic [6:0]  b_prog_len;
    logic [5:0]  b_prog_addr;
    logic [31:0] b_prog_data, b_wa, b_wd, b_ra, b_rd_data, b_err_addr;
    logic        b_we, b_cpu_reset, b_debug, b_done, b_error;
    logic        b_corrupt;

    inst_ram_boot_loader #(.DEPTH(64), .SETTLE_CYCLES(SETTLE), .VERIFY(0), .AUTO_START(1)) u_dut_a (
        .clk(clk), .reset(rst_a_n), .start(a_start), .prog_len(a_prog_len),
        .prog_addr(a_prog_addr), .prog_data(a_prog_data),
        .inst_ram_write_enable(a_we), .inst_ram_write_address(a_wa), .inst_ram_write_data(a_wd),
        .inst_ram_read_address(a_ra), .inst_ram_read_data(32'h0),
        .cpu_reset(a_cpu_reset), .debug(a_debug), .done(a_done), .error(a_error), .err_addr(a_err_addr)
    );

    inst_ram_boot_loader #(.DEPTH(64), .SETTLE_CYCLES(SETTLE), .VERIFY(1), .AUTO_START(1)) u_dut_b (
        .clk(clk), .reset(rst_b_n), .start(b_start), .prog_len(b_prog_len),
        .prog_addr(b_prog_addr), .prog_data(b_prog_data),
        .inst_ram_write_enable(b_we), .inst_ram_write_address(b_wa), .inst_ram_write_data(b_wd),
        .inst_ram_read_address(b_ra), .inst_ram_read_data(b_rd_data),
        .cpu_reset(b_cpu_reset), .debug(b_debug), .done(b_done), .error(b_error), .err_addr(b_err_addr)
    );

    function automatic logic [31:0] rom_word(input int k);
        return (32'h1234_0000 + 32'(k) * 32'h0001_0203) ^ 32'h0F0F_00F0;
    endfunction

    // ROM models: registered read, data one cycle after the address
    always @(posedge clk) a_prog_data <= rom_word(int'(a_prog_addr));
    always @(posedge clk) b_prog_data <= rom_word(int'(b_prog_addr));

    // RAM model for B, with an optional single corrupted word on readback
    logic [31:0] ram [0:63];
    logic [31:0] b_woff, b_roff;
    assign b_woff = b_wa - PC;
    assign b_roff = b_ra - PC;
    always @(posedge clk) begin
        if (b_we) ram[b_woff[7:2]] <= b_wd;
        b_rd_data <= ram[b_roff[7:2]] ^ ((b_corrupt && (b_roff[7:2] == 6'd5)) ? 32'h0000_0100 : 32'h0);
    end

    // Write monitor for A: counts writes, checks address/data order, timestamps first/last write and CPU release
    int          a_wcnt = 0, a_wr_bad = 0, a_first_cyc = 0, a_last_cyc = 0, a_rel_cyc = 0, a_start_cyc = 0;
    logic [31:0] a_first_addr = 0, a_last_addr = 0;
    logic        a_rst_prev = 1'b1;
    always @(negedge clk) begin
        if (a_we) begin
            if (a_wcnt == 0) begin
                a_first_addr = a_wa;
                a_first_cyc  = cyc;
            end
            a_last_cyc  = cyc;
            a_last_addr = a_wa;
            if (a_wa !== PC + 32'(a_wcnt * 4)) a_wr_bad++;
            if (a_wd !== rom_word(a_wcnt)) a_wr_bad++;
            a_wcnt++;
        end
        if (a_rst_prev && !a_cpu_reset) a_rel_cyc = cyc;
        a_rst_prev = a_cpu_reset;
    end

    int b_wcnt = 0;
    always @(negedge clk) if (b_we) b_wcnt++;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_a();
        a_wcnt = 0; a_wr_bad = 0; a_first_cyc = 0; a_last_cyc = 0; a_rel_cyc = 0;
        a_first_addr = 0; a_last_addr = 0;
    endtask

    task automatic pulse_a();
        @(negedge clk);
        a_start = 1'b1;
        a_start_cyc = cyc;
        @(negedge clk);
        a_start = 1'b0;
    endtask

    task automatic pulse_b();
        @(negedge clk);
        b_start = 1'b1;
        @(negedge clk);
        b_start = 1'b0;
    endtask

    task automatic wait_a_done(input string tag, input int budget);
        int n = 0;
        while (!a_done && n < budget) begin
            @(negedge clk);
            #1;
            n++;
        end
        check(tag, 64'(a_done), 64'd1);
    endtask

    task automatic wait_b_end(input string tag, input int budget);
        int n = 0;
        while (!(b_done || b_error) && n < budget) begin
            @(negedge clk);
            #1;
            n++;
        end
        check(tag, 64'(b_done || b_error), 64'd1);
    endtask

    initial begin
        rst_a_n = 1'b1; rst_b_n = 1'b1;
        a_start = 1'b0; b_start = 1'b0;
        a_prog_len = 7'd35; b_prog_len = 7'd8;
        b_corrupt = 1'b0;
        #2;
        rst_a_n = 1'b0; rst_b_n = 1'b0;
        #2;
        // Reset state, before any clock edge
        check("rst_cpu_reset", 64'(a_cpu_reset), 64'd1);
        check("rst_debug",     64'(a_debug),     64'd1);
        check("rst_done",      64'(a_done),      64'd0);
        check("rst_error",     64'(a_error),     64'd0);
        check("rst_we",        64'(a_we),        64'd0);
        check("rst_prog_addr", 64'(a_prog_addr), 64'd0);
        check("rst_err_addr",  64'(b_err_addr),  64'd0);
        check("rst_rd_addr",   64'(b_ra),        64'd0);

        // Test 1: auto-start after release, 35 words, no readback
        clear_a();
        repeat (2) @(negedge clk);
        rst_a_n = 1'b1; rst_b_n = 1'b1;
        wait_a_done("t1_reach_run", 400);
        check("t1_wcnt",       64'(a_wcnt),       64'd35);
        check("t1_wr_bad",     64'(a_wr_bad),     64'd0);
        check("t1_first_addr", 64'(a_first_addr), 64'hbfc00000);
        check("t1_last_addr",  64'(a_last_addr),  64'hbfc00088);
        check("t1_no_gaps",    64'(a_last_cyc - a_first_cyc), 64'd34);
        // Write visible in cycle c lands at edge c+1; release lands SETTLE edges later, seen in cycle c+SETTLE+1
        check("t1_settle",     64'(a_rel_cyc - a_last_cyc),   64'(SETTLE + 1));
        check("t1_cpu_reset",  64'(a_cpu_reset), 64'd0);
        check("t1_debug",      64'(a_debug),     64'd0);
        check("t1_error",      64'(a_error),     64'd0);
        check("t1_run_we",     64'(a_we),        64'd0);
        check("t1_run_paddr",  64'(a_prog_addr), 64'd0);
        check("t1_run_raddr",  64'(a_ra),        64'd0);

        // Test 5: restart from RUN, with an ignored start mid-load
        clear_a();
        a_prog_len = 7'd20;
        pulse_a();
        #1;
        check("t5_cpu_reset_next", 64'(a_cpu_reset), 64'd1);
        check("t5_debug_next",     64'(a_debug),     64'd1);
        check("t5_done_next",      64'(a_done),      64'd0);
        begin
            int n = 0;
            while (a_wcnt < 5 && n < 50) begin
                @(negedge clk);
                #1;
                n++;
            end
        end
        check("t5_midload_reached", 64'(a_wcnt >= 5), 64'd1);
        a_prog_len = 7'd3;
        pulse_a();
        wait_a_done("t5_reach_run", 400);
        check("t5_wcnt",      64'(a_wcnt),      64'd20);
        check("t5_wr_bad",    64'(a_wr_bad),    64'd0);
        check("t5_last_addr", 64'(a_last_addr), 64'hbfc0004c);

        // Test 3: zero-length program
        clear_a();
        a_prog_len = 7'd0;
        pulse_a();
        wait_a_done("t3_reach_run", 200);
        check("t3_wcnt",   64'(a_wcnt), 64'd0);
        // Launch edge ends the start cycle; SETTLE occupies the next SETTLE cycles
        check("t3_settle", 64'(a_rel_cyc - a_start_cyc), 64'(SETTLE + 1));

        // Test 4: length beyond DEPTH clamps to 64 words
        clear_a();
        a_prog_len = 7'd74;
        pulse_a();
        wait_a_done("t4_reach_run", 400);
        check("t4_wcnt",      64'(a_wcnt),      64'd64);
        check("t4_wr_bad",    64'(a_wr_bad),    64'd0);
        check("t4_last_addr", 64'(a_last_addr), 64'hbfc000fc);

        // Test 6: asynchronous reset at write k=10, then auto-restart from word 0
        clear_a();
        a_prog_len = 7'd35;
        pulse_a();
        begin
            int n = 0;
            while (!(a_we && a_wa == PC + 32'd40) && n < 100) begin
                @(negedge clk);
                #1;
                n++;
            end
        end
        check("t6_at_k10", 64'(a_we && a_wa == PC + 32'd40), 64'd1);
        rst_a_n = 1'b0;
        #1;
        check("t6_we_drop",    64'(a_we),        64'd0);
        check("t6_cpu_reset",  64'(a_cpu_reset), 64'd1);
        check("t6_debug",      64'(a_debug),     64'd1);
        check("t6_paddr_zero", 64'(a_prog_addr), 64'd0);
        check("t6_wcnt_k10",   64'(a_wcnt),      64'd11);
        clear_a();
        a_prog_len = 7'd12;
        @(negedge clk);
        rst_a_n = 1'b1;
        wait_a_done("t6_reach_run", 300);
        check("t6_wcnt",       64'(a_wcnt),       64'd12);
        check("t6_first_addr", 64'(a_first_addr), 64'hbfc00000);
        check("t6_wr_bad",     64'(a_wr_bad),     64'd0);

        // Test 2: readback instance; clean auto-start pass, then a corrupted word 5
        check("t2_clean_boot", 64'(b_done), 64'd1);
        b_corrupt = 1'b1;
        b_prog_len = 7'd10;
        b_wcnt = 0;
        pulse_b();
        wait_b_end("t2_reach_end", 300);
        check("t2_error",     64'(b_error),     64'd1);
        check("t2_err_addr",  64'(b_err_addr),  64'hbfc00014);
        check("t2_cpu_reset", 64'(b_cpu_reset), 64'd1);
        check("t2_done",      64'(b_done),      64'd0);
        check("t2_debug",     64'(b_debug),     64'd1);
        check("t2_wcnt",      64'(b_wcnt),      64'd10);
        repeat (3) @(negedge clk);
        #1;
        check("t2_err_hold",  64'(b_err_addr),  64'hbfc00014);
        b_corrupt = 1'b0;
        pulse_b();
        #1;
        check("t2_restart_error", 64'(b_error),    64'd0);
        check("t2_restart_eaddr", 64'(b_err_addr), 64'd0);
        wait_b_end("t2_rerun_end", 300);
        check("t2_rerun_done",  64'(b_done),  64'd1);
        check("t2_rerun_error", 64'(b_error), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
